// File: rtl/effect_switch_sequencer.sv
// Effect switch sequencer.
// The board switches are synchronized and debounced. Volume bits are applied
// directly on audio frame boundaries. Effect bits are applied under a
// fade-down / swap / fade-up sequence, so that effects never switch while
// the audio is at full level.
module effect_switch_sequencer #(
    parameter int DEBOUNCE_CYCLES = 225000,
    parameter int RAMP_STEPS      = 16,
    localparam int GAIN_W         = $clog2(RAMP_STEPS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        sw,
    input  logic              mon_valid,
    input  logic              mon_ready,
    input  logic              mon_last,
    output logic              gate_enable,
    output logic [1:0]        threshold_level,
    output logic              filter_enable,
    output logic              distortion_enable,
    output logic              ringmod_enable,
    output logic [1:0]        ringmod_freq,
    output logic [1:0]        vol_sel,
    output logic [GAIN_W-1:0] mute_gain,
    output logic              busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GAIN_W-1:0] GAIN_FULL = GAIN_W'(RAMP_STEPS);
    localparam logic [GAIN_W-1:0] GAIN_LAST = GAIN_W'(RAMP_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_DOWN = 2'd1,
        SWAP      = 2'd2,
        RAMP_UP   = 2'd3
    } state_t;

    logic [7:0]        meta_reg;
    logic [7:0]        sync_reg;
    logic [7:0]        cand_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [7:0]        deb_reg;
    logic [7:0]        app_reg;
    state_t            state_reg;
    state_t            state_next;
    logic [GAIN_W-1:0] gain_reg;
    logic [GAIN_W-1:0] gain_next;
    logic              busy_reg;
    logic              swap_en;
    logic              fb;
    logic              pend;

    // One stereo frame has passed when the last beat is accepted.
    assign fb   = mon_valid & mon_ready & mon_last;
    // Debounced effect bits differ from the applied ones.
    assign pend = (deb_reg[7:2] != app_reg[7:2]);

    // Two-flop synchronizer for the raw switches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= sw;
            sync_reg <= meta_reg;
        end
    end

    // Debounce: any change restarts the stability count; a full count accepts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand_reg <= '0;
            cnt_reg  <= '0;
            deb_reg  <= '0;
        end else if (sync_reg != cand_reg) begin
            cand_reg <= sync_reg;
            cnt_reg  <= '0;
        end else if (cnt_reg != CNT_MAX) begin
            cnt_reg  <= cnt_reg + 1'b1;
        end else begin
            deb_reg  <= cand_reg;
        end
    end

    // Fade sequencing: next state and next gain.
    always_comb begin
        state_next = state_reg;
        gain_next  = gain_reg;
        swap_en    = 1'b0;
        unique case (state_reg)
            IDLE: begin
                gain_next = GAIN_FULL;
                if (pend) begin
                    state_next = RAMP_DOWN;
                end
            end
            RAMP_DOWN: begin
                // A reverted change wins over a frame boundary in the same cycle.
                if (!pend) begin
                    state_next = RAMP_UP;
                end else if (fb) begin
                    if (gain_reg != '0) begin
                        gain_next = gain_reg - 1'b1;
                    end
                    if (gain_reg <= GAIN_W'(1)) begin
                        state_next = SWAP;
                    end
                end
            end
            SWAP: begin
                swap_en    = 1'b1;
                state_next = RAMP_UP;
            end
            RAMP_UP: begin
                // A fresh change fades down again from wherever the gain is.
                if (pend) begin
                    state_next = RAMP_DOWN;
                end else if (gain_reg >= GAIN_FULL) begin
                    state_next = IDLE;
                end else if (fb) begin
                    gain_next = gain_reg + 1'b1;
                    if (gain_reg == GAIN_LAST) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                gain_next  = GAIN_FULL;
            end
        endcase
    end

    // State, gain and busy registers; busy tracks the registered state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            gain_reg  <= GAIN_FULL;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            gain_reg  <= gain_next;
            busy_reg  <= (state_next != IDLE);
        end
    end

    // Applied controls: effects only in SWAP, volume on every frame boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            app_reg <= '0;
        end else begin
            if (swap_en) begin
                app_reg[7:2] <= deb_reg[7:2];
            end
            if (fb) begin
                app_reg[1:0] <= deb_reg[1:0];
            end
        end
    end

    assign gate_enable       = app_reg[7];
    assign threshold_level   = app_reg[6:5];
    assign ringmod_freq      = app_reg[6:5];
    assign ringmod_enable    = app_reg[4];
    assign distortion_enable = app_reg[3];
    assign filter_enable     = app_reg[2];
    assign vol_sel           = app_reg[1:0];
    assign mute_gain         = gain_reg;
    assign busy              = busy_reg;

endmodule

// File: tb/tb_effect_switch_sequencer.sv
// Randomized and directed bench for effect_switch_sequencer, checked against
// a behavioural model of the switch debounce and fade rules.
module tb_effect_switch_sequencer;

    localparam int D  = 4;
    localparam int R  = 4;
    localparam int GW = $clog2(R + 1);

    localparam int MD_IDLE = 0;
    localparam int MD_DOWN = 1;
    localparam int MD_SWAP = 2;
    localparam int MD_UP   = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    sw = '0;
    logic          mon_valid = 1'b0;
    logic          mon_ready = 1'b0;
    logic          mon_last = 1'b0;
    logic          gate_enable;
    logic [1:0]    threshold_level;
    logic          filter_enable;
    logic          distortion_enable;
    logic          ringmod_enable;
    logic [1:0]    ringmod_freq;
    logic [1:0]    vol_sel;
    logic [GW-1:0] mute_gain;
    logic          busy;

    effect_switch_sequencer #(
        .DEBOUNCE_CYCLES(D),
        .RAMP_STEPS(R)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sw(sw),
        .mon_valid(mon_valid),
        .mon_ready(mon_ready),
        .mon_last(mon_last),
        .gate_enable(gate_enable),
        .threshold_level(threshold_level),
        .filter_enable(filter_enable),
        .distortion_enable(distortion_enable),
        .ringmod_enable(ringmod_enable),
        .ringmod_freq(ringmod_freq),
        .vol_sel(vol_sel),
        .mute_gain(mute_gain),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic rst_drv = 1'b1;

    // Reference model state
    logic [7:0] m_meta, m_sync, m_cand, m_deb, m_app;
    int m_cnt, m_gain, m_mode;
    logic m_busy;

    // Observation flags for directed scenarios
    int seen_busy, seen_gate, seen_dist_early;

    task automatic check_val(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_meta = '0; m_sync = '0; m_cand = '0; m_deb = '0; m_app = '0;
        m_cnt = 0; m_gain = R; m_mode = MD_IDLE; m_busy = 1'b0;
    endtask

    // One clock of the rules: debounce, frame-boundary volume, effect fade.
    task automatic model_step(input logic [7:0] s, input logic f);
        logic [7:0] n_meta, n_sync, n_cand, n_deb, n_app;
        int n_cnt, n_gain, n_mode;
        logic pend;
        n_meta = s; n_sync = m_meta; n_cand = m_cand; n_deb = m_deb;
        n_app = m_app; n_cnt = m_cnt; n_gain = m_gain; n_mode = m_mode;
        pend = (m_deb[7:2] != m_app[7:2]);
        if (m_sync != m_cand) begin
            n_cand = m_sync;
            n_cnt  = 0;
        end else if (m_cnt < D - 1) begin
            n_cnt = m_cnt + 1;
        end else begin
            n_deb = m_cand;
        end
        if (f) n_app[1:0] = m_deb[1:0];
        case (m_mode)
            MD_IDLE: if (pend) n_mode = MD_DOWN;
            MD_DOWN: begin
                if (!pend) n_mode = MD_UP;
                else if (f) begin
                    n_gain = (m_gain > 0) ? m_gain - 1 : 0;
                    if (m_gain <= 1) n_mode = MD_SWAP;
                end
            end
            MD_SWAP: begin
                n_app[7:2] = m_deb[7:2];
                n_mode = MD_UP;
            end
            default: begin
                if (pend) n_mode = MD_DOWN;
                else if (m_gain >= R) n_mode = MD_IDLE;
                else if (f) begin
                    n_gain = m_gain + 1;
                    if (n_gain >= R) n_mode = MD_IDLE;
                end
            end
        endcase
        m_meta = n_meta; m_sync = n_sync; m_cand = n_cand; m_deb = n_deb;
        m_app = n_app; m_cnt = n_cnt; m_gain = n_gain; m_mode = n_mode;
        m_busy = (n_mode != MD_IDLE);
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, "_ctl"}, int'({gate_enable, threshold_level, ringmod_enable,
                                       distortion_enable, filter_enable, vol_sel}), int'(m_app));
        check_val({tag, "_rfreq"}, int'(ringmod_freq), int'(m_app[6:5]));
        check_val({tag, "_gain"}, int'(mute_gain), m_gain);
        check_val({tag, "_busy"}, int'(busy), int'(m_busy));
    endtask

    // One clock: drive at negedge, advance the model at posedge, compare after.
    task automatic step(input logic [7:0] s);
        logic f;
        logic v, r, l;
        @(negedge clk);
        sw = s;
        reset = rst_drv;
        f = ((cyc % 8) == 7);
        v = 1'($urandom); r = 1'($urandom); l = 1'($urandom);
        if (f) begin
            v = 1'b1; r = 1'b1; l = 1'b1;
        end else if (v && r && l) begin
            l = 1'b0;
        end
        mon_valid = v; mon_ready = r; mon_last = l;
        #1;
        if (reset) begin
            model_reset();
            check_outputs("async_rst");
        end
        @(posedge clk);
        if (reset) model_reset();
        else model_step(s, f);
        cyc++;
        #1;
        check_outputs("cyc");
        if (busy) seen_busy++;
        if (gate_enable) seen_gate++;
        if (distortion_enable && mute_gain != 0 && busy && m_mode == MD_DOWN) seen_dist_early++;
    endtask

    task automatic run(input logic [7:0] s, input int n);
        for (int i = 0; i < n; i++) step(s);
    endtask

    initial begin
        model_reset();
        run(8'h00, 3);
        rst_drv = 1'b0;

        // Idle with all switches off.
        seen_busy = 0;
        run(8'h00, 200);
        check_val("idle_busy_seen", seen_busy, 0);

        // Single effect bit: full fade down, swap, fade up.
        seen_busy = 0; seen_dist_early = 0;
        run(8'h08, 150);
        check_val("dist_busy_rose", int'(seen_busy > 0), 1);
        check_val("dist_early", seen_dist_early, 0);
        check_val("dist_applied", int'(distortion_enable), 1);
        run(8'h00, 150);

        // Volume only: no fade.
        seen_busy = 0;
        run(8'h03, 100);
        check_val("vol_busy_seen", seen_busy, 0);
        check_val("vol_applied", int'(vol_sel), 3);
        run(8'h00, 100);

        // Short glitch never reaches the debounced value.
        seen_busy = 0;
        run(8'h04, 3);
        run(8'h00, 100);
        check_val("glitch_busy_seen", seen_busy, 0);
        check_val("glitch_filter", int'(filter_enable), 0);

        // Revert during fade down: climb back without swapping.
        seen_gate = 0;
        begin
            int guard = 0;
            while (!(m_mode == MD_DOWN && m_gain == 2) && guard < 300) begin
                step(8'h80);
                guard++;
            end
            check_val("abort_reached_gain2", int'(guard < 300), 1);
        end
        run(8'h00, 150);
        check_val("abort_gate_seen", seen_gate, 0);
        check_val("abort_gain_back", int'(mute_gain), R);

        // Reset in the middle of a fade, then a complete ramp afterwards.
        begin
            int guard = 0;
            while (!(m_mode == MD_DOWN && m_gain == 1) && guard < 300) begin
                step(8'h08);
                guard++;
            end
            check_val("rst_reached_gain1", int'(guard < 300), 1);
        end
        rst_drv = 1'b1;
        run(8'h08, 3);
        rst_drv = 1'b0;
        run(8'h08, 150);
        check_val("rst_reramp_dist", int'(distortion_enable), 1);
        check_val("rst_reramp_idle", int'(busy), 0);

        // Random switch activity with occasional resets.
        for (int t = 0; t < 50; t++) begin
            logic [7:0] s;
            int hold;
            s = 8'($urandom);
            if ($urandom_range(0, 3) == 0) s[7:2] = m_deb[7:2];
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(10, 120);
            if ($urandom_range(0, 11) == 0) begin
                rst_drv = 1'b1;
                run(s, $urandom_range(1, 3));
                rst_drv = 1'b0;
            end
            run(s, hold);
        end
        run(8'h00, 150);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/effect_switch_sequencer.md
EFFECT_SWITCH_SEQUENCER -- requirements
Module: effect_switch_sequencer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 225000; this is the number of stable clk cycles required before a switch change is accepted (about 10 ms at 22.591 MHz).
REQ-002 The block SHALL have parameter RAMP_STEPS, default 16; this is the number of audio frames per fade-down or fade-up; legal range 2..255.
REQ-003 The block SHALL have ports clk, in, 1 -- the single clock (axis_clk domain).
REQ-004 The block SHALL have ports reset, in, 1 -- asynchronous, active-high reset.
REQ-005 The block SHALL have ports sw, in, 8 -- raw board switches, asynchronous to clk.
REQ-006 The block SHALL have ports mon_valid / mon_ready / mon_last, in, 1 each -- snoop of the transmit-side AXIS handshake.
REQ-007 The block SHALL have ports gate_enable (1), threshold_level (2), filter_enable (1), distortion_enable (1), ringmod_enable (1), ringmod_freq (2), out -- applied effect controls.
REQ-008 The block SHALL have ports vol_sel, out, 2 -- applied volume select.
REQ-009 The block SHALL have ports mute_gain, out, GAIN_W = clog2(RAMP_STEPS+1) -- fade multiplier; the volume stage scales audio by mute_gain/RAMP_STEPS.
REQ-010 The block SHALL have ports busy, out, 1 -- high whenever the FSM is not IDLE.

Function
REQ-011 Synchronizer: sw SHALL pass through a 2-flop synchronizer (sync) before any other use.
REQ-012 Debounce, mismatch: when sync != cand, the block SHALL load cand <= sync and set cnt <= 0.
REQ-013 Debounce, match: when sync == cand and cnt < DEBOUNCE_CYCLES-1, cnt SHALL increment.
REQ-014 Debounce, accept: when sync == cand and cnt == DEBOUNCE_CYCLES-1, the block SHALL set deb <= cand, and cnt SHALL hold.
REQ-015 Debounce timing: a sync toggle shorter than DEBOUNCE_CYCLES cycles SHALL never reach deb.
REQ-016 Frame boundary: fb SHALL be defined as mon_valid & mon_ready & mon_last; this is one stereo frame.
REQ-017 Output mapping: applied register app[7:0] SHALL drive gate_enable=app[7], threshold_level=app[6:5], ringmod_freq=app[6:5], ringmod_enable=app[4], distortion_enable=app[3], filter_enable=app[2], vol_sel=app[1:0].
REQ-018 Volume bits: app[1:0] SHALL load deb[1:0] on any fb, in any state, with no fade.
REQ-019 FSM states SHALL be IDLE, RAMP_DOWN, SWAP, RAMP_UP.
REQ-020 IDLE: mute_gain SHALL equal RAMP_STEPS; if deb[7:2] != app[7:2], the FSM SHALL go to RAMP_DOWN; no gain change in this cycle.
REQ-021 RAMP_DOWN: on each fb, mute_gain SHALL decrement by 1; on the fb where mute_gain goes 1->0, the FSM SHALL go to SWAP.
REQ-022 RAMP_DOWN abort: if deb[7:2] == app[7:2] (change reverted), the FSM SHALL go to RAMP_UP without a swap; an abort and an fb in the same cycle SHALL give the transition priority, with no decrement.
REQ-023 SWAP: for exactly one cycle, the block SHALL set app[7:2] <= deb[7:2], sampled in that cycle; the FSM SHALL then go to RAMP_UP; mute_gain SHALL stay 0.
REQ-024 RAMP_UP: on each fb, mute_gain SHALL increment by 1; on reaching RAMP_STEPS, the FSM SHALL go to IDLE.
REQ-025 RAMP_UP retarget: if deb[7:2] != app[7:2], the FSM SHALL go to RAMP_DOWN, continuing from the current mute_gain.
REQ-026 Range: mute_gain SHALL saturate within 0..RAMP_STEPS and never wrap.
REQ-027 Timing of deb updates: a deb update coinciding with fb SHALL take effect in the FSM on the following cycle.
REQ-028 Register timing: all outputs SHALL be registered; busy SHALL equal (state != IDLE) registered with state.
REQ-029 Enable-bit stability: enable bits SHALL change only in SWAP (app[7:2]) or on fb (app[1:0]).

Reset
REQ-030 While reset is high, all registers SHALL clear asynchronously: sync, cand, deb, app = 0; cnt = 0; state = IDLE; mute_gain = RAMP_STEPS; busy = 0; all effect/vol outputs = 0.
REQ-031 Reset asserted mid-ramp SHALL abort immediately to the reset values; no partial swap SHALL be retained.
REQ-032 After reset release with nonzero sw, the block SHALL perform a normal debounce and ramp to apply the switches.

Verification (bench: DEBOUNCE_CYCLES=4, RAMP_STEPS=4, fb pulsed every 8 cycles)
REQ-033 Reset release with sw=0x00, 200 cycles -> all outputs 0, mute_gain=4, busy=0 throughout.
REQ-034 sw 0x00->0x08, held -> busy rises; mute_gain steps 4,3,2,1,0 on successive fb; distortion_enable=1 only after mute_gain=0; mute_gain steps 1..4, then busy=0.
REQ-035 sw 0x00->0x03, held -> vol_sel=3 on the first fb after debounce; mute_gain stays 4; busy stays 0.
REQ-036 sw glitch to 0x04 for 3 cycles, then back to 0x00 -> deb unchanged; filter_enable=0; busy=0.
REQ-037 sw 0x00->0x80; after mute_gain reaches 2, sw returns to 0x00 (debounced) -> abort: mute_gain climbs 2->4 with no swap; gate_enable never 1.
REQ-038 Reset asserted during RAMP_DOWN with mute_gain=1 -> same cycle: mute_gain=4, state IDLE, app=0; after release with sw still 0x08, a full new ramp completes.
